// File: rtl/motor_status_pkg.sv
// motor_status_pkg: shared tags, field widths and FSM encoding for the motor status frame decoder
package motor_status_pkg;
  localparam int NUM_MOTORS = 10;
  localparam int PAYLOAD_W = 5;
  localparam logic [1:0] TAG_PEND_LO = 2'd0;
  localparam logic [1:0] TAG_PEND_HI = 2'd1;
  localparam logic [1:0] TAG_TERM_LO = 2'd2;
  localparam logic [1:0] TAG_TERM_HI = 2'd3;
  typedef enum logic [1:0] {IDLE, GOT0, GOT1, GOT2} rxState_t;
endpackage

// File: rtl/status_timeout_counter.sv
// status_timeout_counter: saturating idle counter that flags expiry at LIMIT-1
module status_timeout_counter #(
  parameter int LIMIT = 16384,
  parameter int CNT_W = 21
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  assign expired = cnt == CNT_W'(LIMIT - 1);
  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/motor_status_rx_decoder.sv
// motor_status_rx_decoder: reassembles tagged UART bytes into pending/term vectors, committed atomically per good frame
module motor_status_rx_decoder import motor_status_pkg::*; #(
  parameter int BYTE_GAP_TIMEOUT = 16384,
  parameter int LINK_TIMEOUT = 1048576,
  parameter int CNT_W = 21
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [NUM_MOTORS-1:0] pending,
  output logic [NUM_MOTORS-1:0] term,
  output logic [NUM_MOTORS-1:0] term_edge,
  output logic                  status_valid,
  output logic                  link_ok,
  output logic                  frame_err,
  output logic [7:0]            err_count,
  output logic [15:0]           frame_count
);
  rxState_t state, nextState;
  logic [1:0] tag;
  logic [PAYLOAD_W-1:0] stagePendLo, stagePendHi, stageTermLo;
  logic [NUM_MOTORS-1:0] newTerm;
  logic seqOk, commit, abort, gapExpired, linkExpired;
  always_comb begin
    tag = rx_data[7:6];
    seqOk = !rx_data[5] && (tag == TAG_PEND_LO || (tag == TAG_PEND_HI && state == GOT0) ||
            (tag == TAG_TERM_LO && state == GOT1) || (tag == TAG_TERM_HI && state == GOT2));
    commit = rx_valid && seqOk && tag == TAG_TERM_HI;
    // a fresh tag0 always restarts the frame, but discards any partial one as an error
    abort = rx_valid ? (!seqOk || (tag == TAG_PEND_LO && state != IDLE)) : (gapExpired && state != IDLE);
    nextState = !rx_valid ? (abort ? IDLE : state) : !seqOk ? IDLE :
                tag == TAG_PEND_LO ? GOT0 : tag == TAG_PEND_HI ? GOT1 : tag == TAG_TERM_LO ? GOT2 : IDLE;
    newTerm = {rx_data[PAYLOAD_W-1:0], stageTermLo};
  end
  status_timeout_counter #(.LIMIT(BYTE_GAP_TIMEOUT), .CNT_W(CNT_W)) gapTimer (
    .CLK(CLK), .reset_n(reset_n), .clear(rx_valid || state == IDLE),
    .enable(state != IDLE), .expired(gapExpired)
  );
  status_timeout_counter #(.LIMIT(LINK_TIMEOUT), .CNT_W(CNT_W)) linkTimer (
    .CLK(CLK), .reset_n(reset_n), .clear(commit), .enable(1'b1), .expired(linkExpired)
  );
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      stagePendLo <= '0;
      stagePendHi <= '0;
      stageTermLo <= '0;
      pending <= '0;
      term <= '0;
      term_edge <= '0;
      status_valid <= 1'b0;
      link_ok <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
      frame_count <= '0;
    end else begin
      state <= nextState;
      status_valid <= commit;
      frame_err <= abort;
      if (rx_valid && tag == TAG_PEND_LO) stagePendLo <= rx_data[PAYLOAD_W-1:0];
      if (rx_valid && tag == TAG_PEND_HI) stagePendHi <= rx_data[PAYLOAD_W-1:0];
      if (rx_valid && tag == TAG_TERM_LO) stageTermLo <= rx_data[PAYLOAD_W-1:0];
      if (abort && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (commit) begin
        pending <= {stagePendHi, stagePendLo};
        term <= newTerm;
        term_edge <= newTerm ^ term;
        frame_count <= frame_count + 16'd1;
        link_ok <= 1'b1;
      end else if (linkExpired) link_ok <= 1'b0;
    end
  end
endmodule

// File: tb/tb_motor_status_rx_decoder.sv
// tb_motor_status_rx_decoder: directed and randomized frames checked every cycle against a frame-level model
module tb_motor_status_rx_decoder;
  localparam int GAP = 64;
  localparam int LINK = 1024;
  logic CLK, reset_n, rx_valid, status_valid, link_ok, frame_err;
  logic [7:0] rx_data, err_count;
  logic [9:0] pending, term, term_edge;
  logic [15:0] frame_count;
  int vectors = 0, miscompares = 0;

  motor_status_rx_decoder #(.BYTE_GAP_TIMEOUT(GAP), .LINK_TIMEOUT(LINK), .CNT_W(11)) dut (
    .CLK(CLK), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pending(pending), .term(term), .term_edge(term_edge), .status_valid(status_valid),
    .link_ok(link_ok), .frame_err(frame_err), .err_count(err_count), .frame_count(frame_count)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // model state: what the outputs must be after the most recent clock edge
  logic [9:0] mPend, mTerm, mEdge;
  logic mSv, mLink, mFe;
  logic [7:0] mErr;
  logic [15:0] mFc;
  logic [4:0] sLo, sHi, sTlo;
  int nGot, gapAge, linkAge;

  task automatic modelReset();
    mPend = 0; mTerm = 0; mEdge = 0; mSv = 0; mLink = 0; mFe = 0; mErr = 0; mFc = 0;
    sLo = 0; sHi = 0; sTlo = 0; nGot = 0; gapAge = 0; linkAge = 0;
  endtask

  task automatic modelStep(input logic v, input logic [7:0] d);
    logic abort, commit;
    logic [9:0] newTerm;
    int tag;
    abort = 0; commit = 0; newTerm = 0;
    tag = int'(d[7:6]);
    if (v) begin
      if (d[5]) begin abort = 1; nGot = 0; end
      else if (tag == 0) begin abort = nGot > 0; sLo = d[4:0]; nGot = 1; end
      else if (tag == nGot && tag < 3) begin
        if (tag == 1) sHi = d[4:0]; else sTlo = d[4:0];
        nGot++;
      end else if (tag == 3 && nGot == 3) begin commit = 1; nGot = 0; newTerm = {d[4:0], sTlo}; end
      else begin abort = 1; nGot = 0; end
      gapAge = 0;
    end else if (nGot > 0) begin
      if (gapAge >= GAP - 1) begin abort = 1; nGot = 0; gapAge = 0; end
      else gapAge++;
    end else gapAge = 0;
    if (commit) begin
      mEdge = newTerm ^ mTerm;
      mTerm = newTerm;
      mPend = {sHi, sLo};
      mFc = mFc + 16'd1;
      mLink = 1;
      linkAge = 0;
    end else if (linkAge >= LINK - 1) mLink = 0;
    else linkAge++;
    if (abort && mErr != 8'hFF) mErr = mErr + 8'd1;
    mSv = commit;
    mFe = abort;
  endtask

  initial begin
    logic [56:0] act, expv;
    modelReset();
    forever begin
      @(negedge CLK);
      if (!reset_n) modelReset();
      act = {pending, term, status_valid ? term_edge : 10'd0, status_valid, link_ok, frame_err, err_count, frame_count};
      expv = {mPend, mTerm, mSv ? mEdge : 10'd0, mSv, mLink, mFe, mErr, mFc};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL outputs @%0t: got %h expected %h", $time, act, expv);
      end
      if (reset_n) modelStep(rx_valid, rx_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitN(input int n);
    repeat (n) tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1;
    rx_data = b;
    tick();
    rx_valid = 0;
    rx_data = 8'($urandom);
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, input int gap);
    sendByte(b0); waitN(gap);
    sendByte(b1); waitN(gap);
    sendByte(b2); waitN(gap);
    sendByte(b3);
  endtask

  initial begin
    int genTag;
    logic [7:0] b;
    reset_n = 0; rx_valid = 0; rx_data = 0;
    repeat (3) @(posedge CLK);
    #1 reset_n = 1;
    chk("reset_pending", 32'(pending), 0);
    chk("reset_link_ok", 32'(link_ok), 0);
    chk("reset_frame_count", 32'(frame_count), 0);

    sendFrame(8'h05, 8'h55, 8'h9F, 8'hDF, 20);
    chk("f1_status_valid", 32'(status_valid), 1);
    chk("f1_pending", 32'(pending), 32'h2A5);
    chk("f1_term", 32'(term), 32'h3FF);
    chk("f1_term_edge", 32'(term_edge), 32'h3FF);
    chk("f1_frame_count", 32'(frame_count), 1);
    chk("f1_link_ok", 32'(link_ok), 1);
    tick();
    chk("f1_sv_one_cycle", 32'(status_valid), 0);

    sendFrame(8'h05, 8'h55, 8'h9E, 8'hDF, 20);
    chk("f2_term", 32'(term), 32'h3FE);
    chk("f2_term_edge", 32'(term_edge), 32'h001);
    chk("f2_frame_count", 32'(frame_count), 2);
    chk("f2_err_count", 32'(err_count), 0);
    waitN(5);

    sendByte(8'h05); waitN(3); sendByte(8'h9F);
    chk("seq_frame_err", 32'(frame_err), 1);
    chk("seq_err_count", 32'(err_count), 1);
    chk("seq_pending_held", 32'(pending), 32'h2A5);
    waitN(5);

    sendByte(8'h05); sendByte(8'h45);
    sendFrame(8'h05, 8'h55, 8'h9F, 8'hDF, 2);
    chk("restart_err_count", 32'(err_count), 2);
    chk("restart_pending", 32'(pending), 32'h2A5);
    chk("restart_frame_count", 32'(frame_count), 3);
    waitN(5);

    sendByte(8'h25); waitN(3);
    sendByte(8'h05); sendByte(8'h75);
    chk("bit5_status_valid", 32'(status_valid), 0);
    chk("bit5_err_count", 32'(err_count), 4);
    waitN(5);

    sendByte(8'h05); sendByte(8'h55); waitN(GAP);
    chk("gap_frame_err", 32'(frame_err), 1);
    sendByte(8'h9F); sendByte(8'hDF);
    chk("gap_no_commit", 32'(frame_count), 3);
    chk("gap_err_count", 32'(err_count), 7);
    waitN(5);
    sendByte(8'h05); sendByte(8'h55); waitN(GAP - 1);
    sendByte(8'h9F); sendByte(8'hDF);
    chk("gap_edge_commit", 32'(frame_count), 4);

    waitN(LINK + 5);
    chk("link_lost", 32'(link_ok), 0);
    chk("link_lost_pending", 32'(pending), 32'h2A5);
    sendFrame(8'h03, 8'h4C, 8'h81, 8'hD0, 1);
    chk("link_restored", 32'(link_ok), 1);
    chk("link_restored_pending", 32'(pending), 32'h183);

    for (int i = 0; i < 300; i++) begin sendByte(8'h9F); tick(); end
    chk("err_saturate", 32'(err_count), 32'hFF);

    genTag = 0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      b = 8'($urandom);
      if (r < 80) b = {2'(genTag), 1'b0, b[4:0]};
      else if (r >= 90) b[5] = 1'b1;
      genTag = (int'(b[7:6]) + 1) % 4;
      sendByte(b);
      waitN($urandom_range(0, 9) == 0 ? $urandom_range(GAP - 8, GAP + 4) : $urandom_range(0, 5));
    end

    sendByte(8'h05); sendByte(8'h55);
    #2 reset_n = 0;
    #1;
    chk("async_reset_pending", 32'(pending), 0);
    chk("async_reset_term", 32'(term), 0);
    chk("async_reset_counts", {err_count, frame_count}, 0);
    chk("async_reset_flags", {29'd0, link_ok, status_valid, frame_err}, 0);
    tick();
    reset_n = 1;
    sendByte(8'h9F); sendByte(8'hDF);
    chk("post_reset_no_commit", 32'(frame_count), 0);
    sendFrame(8'h05, 8'h55, 8'h9F, 8'hDF, 3);
    chk("post_reset_frame_count", 32'(frame_count), 1);
    chk("post_reset_err_count", 32'(err_count), 2);
    waitN(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/motor_status_rx_decoder.md
Name: motor_status_rx_decoder

Overview:
- Receive-side decoder for the 4-byte motor status frame that the motor-control CPLD streams over UART.
- Sits after a UART byte receiver (single-cycle byte strobe) in the host/controller-side logic.
- Validates the tag and sequence of each byte, reassembles the 10-bit dataPending and 10-bit term vectors, and commits them atomically per good frame.
- Reports link health, per-frame errors and termination-switch edges.

Parameters:
- BYTE_GAP_TIMEOUT, 16384, max idle cycles between bytes inside a frame before the frame is aborted.
- LINK_TIMEOUT, 1048576, cycles without a good frame before link_ok drops.
- CNT_W, 21, width of the shared gap/link counters; must hold LINK_TIMEOUT.

Ports:
- CLK  in  1  system clock (24 MHz).
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  single-cycle strobe, rx_data valid.
- pending  out  10  last committed dataPending vector.
- term  out  10  last committed termination-input vector.
- term_edge  out  10  XOR of new and previous term; valid with status_valid.
- status_valid  out  1  one-cycle pulse per committed frame.
- link_ok  out  1  high while good frames keep arriving within LINK_TIMEOUT.
- frame_err  out  1  one-cycle pulse per aborted frame.
- err_count  out  8  saturating count of aborted frames.
- frame_count  out  16  wrapping count of good frames.

Behaviour:
- Reset: asynchronous, active-low. All outputs and state are 0; the FSM is in IDLE.
- Byte format: [7:6] tag (0..3); [5] must be 0; [4:0] payload.
  - tag0 = pending[4:0]
  - tag1 = pending[9:5]
  - tag2 = term[4:0]
  - tag3 = term[9:5]
- FSM states: IDLE, GOT0, GOT1, GOT2. Staging registers hold partial payloads; outputs change only on commit.
- Byte handling, evaluated on a rx_valid cycle:
  - bit5=1: abort and go to IDLE.
  - tag0 in any state: store payload and go to GOT0. If the state was GOT0..GOT2, also abort (error, no commit).
  - tag1 in GOT0 → GOT1. tag2 in GOT1 → GOT2. Any other tag1/tag2/tag3 in an unexpected state: abort and go to IDLE.
  - tag3 in GOT2: commit and go to IDLE.
- Commit (same edge as the tag3 strobe): update pending/term, compute term_edge = new term ^ old term, increment frame_count (wraps 0xFFFF→0), set link_ok=1, clear the link counter.
  - status_valid is high for exactly the one cycle after that edge. Latency from the tag3 strobe is 1 cycle.
- Abort: frame_err pulses for one cycle after the abort edge. err_count increments and saturates at 0xFF. Staged data is discarded; committed outputs are unchanged.
- Gap timer:
  - Cleared on every rx_valid; counts only in GOT0..GOT2.
  - Reaching BYTE_GAP_TIMEOUT-1 with no rx_valid: abort and go to IDLE.
  - If rx_valid and expiry fall on the same cycle, the byte wins and no timeout occurs.
- Link timer:
  - Counts every cycle, saturates, and is cleared on commit.
  - When it reaches LINK_TIMEOUT-1, link_ok goes to 0. pending/term hold their last values.
  - A commit on that same cycle keeps link_ok=1.
- Reset mid-frame: staged data is lost; the first frame after reset needs tag0 first.
- term_edge holds its value between commits; it is meaningful only while status_valid is high.

Decomposition:
- Shared package motor_status_pkg:
  - tag constants TAG_PEND_LO=0, TAG_PEND_HI=1, TAG_TERM_LO=2, TAG_TERM_HI=3
  - FSM state encoding
  - NUM_MOTORS=10, PAYLOAD_W=5
- One natural sub-module, status_timeout_counter (clear, enable, saturating compare to a parameter, expire flag). It is instantiated twice: gap timer and link timer.

Test Plan:
- Good frame: bytes 0x05, 0x55, 0x9F, 0xDF, spaced 6000 cycles apart → pending=0x2A5, term=0x3FF, term_edge=0x3FF, status_valid pulses once 1 cycle after 0xDF, frame_count=1, link_ok=1.
- Repeat the frame with the third byte 0x9E → term=0x3FE, term_edge=0x001, frame_count=2, err_count=0.
- Sequence errors:
  - 0x05, 0x9F → frame_err pulse, err_count=1, outputs unchanged.
  - 0x05, 0x45, 0x05, 0x55, 0x9F, 0xDF → one abort, then commit with pending=0x2A5.
- Bit5 set: 0x25 as the first byte, or 0x75 in place of byte 2 → abort, err_count increments, no status_valid.
- Gap timeout: 0x05, 0x55, then silence for 16384 cycles → frame_err, return to IDLE. A subsequent 0x9F, 0xDF gives no commit. A byte on the exact expiry cycle is accepted instead.
- Link loss and saturation:
  - No frames for 1048576 cycles after a commit → link_ok=0, pending/term retained. The next good frame restores link_ok=1.
  - 300 bad frames → err_count=0xFF.
  - Async reset asserted mid-frame → all outputs 0 immediately.
